// File: rtl/mulacc.sv
// Sequential unsigned multiply-accumulate, p = a*b + c, one multiplier bit per clock (LSB first).
// Shares the trigger/done handshake of the control-path divider and reconstructs its dividend.
//
// state | meaning
// IDLE  | no computation running, busy low
// CALC  | shift-add step k (0..WIDTH-1) executes on each edge
module mulacc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo,
  output logic             ovf
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             load;
  logic             step;
  logic             finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A trigger always wins, including on the completion edge, so a restart suppresses done.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (trigger) begin
      load      = 1'b1;
      state_nxt = CALC;
    end else if (state == CALC) begin
      step = 1'b1;
      if (k == K_LAST) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  assign busy = (state == CALC);

  // The carry out of the add is shifted straight into hi, so it never needs its own register.
  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) sum = {1'b0, hi} + {1'b0, mcand};
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mcand <= b;
        hi    <= c;
        lo    <= a;
        k     <= '0;
      end else if (step) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
        k  <= k + KW'(1);
        if (finish) begin
          p_hi <= hi_nxt;
          p_lo <= lo_nxt;
          ovf  <= |hi_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mulacc.sv
// Scoreboard bench for mulacc: stimulus pushes expected results, a negedge monitor checks each done.
module tb_mulacc;

  typedef struct {
    int unsigned cyc;
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig32 = 1'b0, trig8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, c32 = '0;
  logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
  logic        busy32, done32, ovf32, busy8, done8, ovf8;
  logic [31:0] p_hi32, p_lo32;
  logic [7:0]  p_hi8, p_lo8;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q32[$];
  exp_t        q8[$];

  mulacc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .trigger(trig32), .a(a32), .b(b32), .c(c32),
    .busy(busy32), .done(done32), .p_hi(p_hi32), .p_lo(p_lo32), .ovf(ovf32)
  );

  mulacc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .trigger(trig8), .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .p_hi(p_hi8), .p_lo(p_lo8), .ovf(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done32) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", 64'(done32), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("done32_cycle", 64'(cyc), 64'(e.cyc));
        chk("result32", {p_hi32, p_lo32}, e.p);
        chk("ovf32", 64'(ovf32), 64'(e.ovf));
      end
    end
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("done8_cycle", 64'(cyc), 64'(e.cyc));
        chk("result8", {48'd0, p_hi8, p_lo8}, e.p);
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
      end
    end
  end

  // Call at a negedge; returns 1 ns after the trigger edge.
  task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input bit expect_done, input logic [63:0] res, input logic o);
    a32 = a; b32 = b; c32 = c; trig32 = 1'b1;
    @(posedge clk); #1;
    trig32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; c32 = 32'hFFFF_0000;
    if (expect_done) q32.push_back('{cyc: cyc + 32, p: res, ovf: o});
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [15:0] res);
    a8 = a; b8 = b; c8 = c; trig8 = 1'b1;
    @(posedge clk); #1;
    trig8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hFF;
    q8.push_back('{cyc: cyc + 8, p: {48'd0, res}, ovf: |res[15:8]});
  endtask

  task automatic wait_done(input bit sel8, input string name);
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = sel8 ? done8 : done32;
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    int bc;
    int dc;
    bit seen;

    #12;
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_p", {p_hi32, p_lo32}, 64'd0);
    chk("rst_ovf", 64'(ovf32), 64'd0);
    @(negedge clk); rst = 1'b0;

    // basic, plus busy length
    @(negedge clk);
    go32(32'd1234, 32'd5678, 32'd9, 1, 64'd7006661, 1'b0);
    bc = 0; seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (done32) seen = 1;
      else if (busy32) bc++;
    end
    chk("basic_done_seen", 64'(seen), 64'd1);
    chk("basic_busy_len", 64'(bc), 64'd32);
    chk("basic_busy_after", 64'(busy32), 64'd0);

    // maximum operands
    @(negedge clk);
    go32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFF_0000_0000, 1'b1);
    wait_done(0, "max_timeout");

    // 8-bit zero multiplier and divider round-trip
    @(negedge clk);
    go8(8'd0, 8'hAB, 8'h55, 16'h0055);
    wait_done(1, "zero8_timeout");
    @(negedge clk);
    go8(8'd14, 8'd7, 8'd2, 16'd100);
    wait_done(1, "rt8_timeout");

    // abort 10 cycles in: only the restarted computation completes
    @(negedge clk);
    go32(32'd3, 32'd4, 32'd0, 0, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    go32(32'd5, 32'd6, 32'd1, 1, 64'd31, 1'b0);
    wait_done(0, "abort_timeout");

    // restart on the completion edge suppresses done and the result update
    @(negedge clk);
    go32(32'd7, 32'd8, 32'd0, 0, 64'd0, 1'b0);
    repeat (31) @(posedge clk);
    @(negedge clk);
    go32(32'd9, 32'd10, 32'd1, 1, 64'd91, 1'b0);
    chk("cedge_done", 64'(done32), 64'd0);
    chk("cedge_busy", 64'(busy32), 64'd1);
    chk("cedge_hold", 64'(p_lo32), 64'd31);
    wait_done(0, "cedge_timeout");

    // asynchronous reset between edges, mid computation
    @(negedge clk);
    go32(32'd100, 32'd200, 32'd3, 0, 64'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy32), 64'd0);
    chk("arst_done", 64'(done32), 64'd0);
    chk("arst_p", {p_hi32, p_lo32}, 64'd0);
    chk("arst_ovf", 64'(ovf32), 64'd0);
    @(negedge clk); rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (done32) dc++;
    end
    chk("arst_no_done", 64'(dc), 64'd0);

    // back-to-back: second trigger in the first done cycle
    @(negedge clk);
    go32(32'd2, 32'd3, 32'd0, 1, 64'd6, 1'b0);
    wait_done(0, "b2b_first_timeout");
    go32(32'd4, 32'd5, 32'd6, 1, 64'd26, 1'b0);
    repeat (16) @(negedge clk);
    chk("b2b_hold", 64'(p_lo32), 64'd6);
    chk("b2b_busy", 64'(busy32), 64'd1);
    wait_done(0, "b2b_second_timeout");

    repeat (4) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mulacc.md
# mulacc

Sequential unsigned multiply-accumulate unit computing `p = a * b + c` at full 2·WIDTH precision. It processes one multiplier bit per clock, least-significant bit first. It is the inverse companion of the control-path divider: feeding it the divider's quotient, divisor and remainder reconstructs the dividend, i.e. `q * b + r == a`. It sits beside the divider in the control datapath and uses the same trigger/done handshake, so the sequencer drives both the same way.

## Interface
- `WIDTH`, 32, operand width in bits; legal values are ≥ 2.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `trigger`  in  1  start pulse; operands are sampled on the edge where `trigger` is high.
- `a`  in  WIDTH  multiplier, unsigned.
- `b`  in  WIDTH  multiplicand, unsigned.
- `c`  in  WIDTH  addend, unsigned.
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse; the result is valid from this cycle on.
- `p_hi`  out  WIDTH  upper half of the result.
- `p_lo`  out  WIDTH  lower half of the result.
- `ovf`  out  1  high when `p_hi != 0`, i.e. the result does not fit in WIDTH bits; updated together with the result.

## Operation
- States:
  - IDLE: `busy` = 0.
  - CALC: `busy` = 1, iteration counter `k` runs 0..WIDTH-1.
- Start: `trigger` high at an edge, in any state, latches `b` into the multiplicand register and loads the working register `{carry, hi, lo} = {0, c, a}`. It also clears `k` and enters CALC.
- Per CALC edge:
  - If `lo[0]` is 1, `{carry, hi} = hi + b` (WIDTH+1 bits); otherwise `carry = 0`.
  - Then shift `{carry, hi, lo}` right by one, and increment `k`.
  - After WIDTH steps, `{hi, lo} = a*b + c`. This never exceeds 2^(2·WIDTH)-1, so no bits are lost.
- Completion, on the edge that performs step `k == WIDTH-1`:
  - `p_hi`/`p_lo` take the final working value.
  - `ovf` is set from that value.
  - `done` is set to 1, `busy` is cleared, and the block returns to IDLE.
- `done` is cleared on the following edge unless another completion occurs on that edge.
- `p_hi`, `p_lo` and `ovf` hold their last completed result indefinitely. They never show intermediate values.
- Boundary rules:
  - Trigger while in CALC: the running computation is aborted and restarted with the new operands. The aborted computation produces no `done` and no result update.
  - Trigger on the completion edge: the restart wins. No `done`, no result update, and `busy` stays 1.
  - Trigger in the cycle `done` is high: the computation is legal and starts normally. The `done` pulse already visible is unaffected.
  - Operand inputs are ignored except on trigger edges, so they may change freely during CALC.
  - `b = 0` or `a = 0`: the result is `c`, and the same latency applies (no early exit).
- Reset: `rst` high forces, immediately and regardless of `clk`: IDLE, `busy` = 0, `done` = 0, `p_hi` = 0, `p_lo` = 0, `ovf` = 0, working registers and counter cleared.
  - Reset mid-computation discards that computation. No `done` follows after release.
  - `trigger` is ignored while `rst` is high.

## Timing
- Let T0 be the edge sampling `trigger`. Then `busy` = 1 from after T0 through the edge T0+WIDTH, exclusive.
- Steps execute on edges T0+1 … T0+WIDTH.
- Results and `done` become visible after edge T0+WIDTH. Latency is fixed at WIDTH cycles from trigger to `done`.
- `done` is high for exactly one cycle, T0+WIDTH to T0+WIDTH+1.
- Maximum throughput: one result per WIDTH cycles, achieved by triggering in the `done` cycle.
- The longest combinational path is the WIDTH+1-bit add plus the mux into the working register. There is no combinational path from inputs to outputs.

## Test plan
- Basic, WIDTH=32: `a` = 1234, `b` = 5678, `c` = 9 → `done` exactly 32 edges after the trigger edge; `p_lo` = 7006661, `p_hi` = 0, `ovf` = 0; `busy` high for exactly 32 cycles.
- Maximum, WIDTH=32: `a` = `b` = `c` = 0xFFFFFFFF → `p_hi` = 0xFFFFFFFF, `p_lo` = 0x00000000, `ovf` = 1.
- Zero and divider round-trip, WIDTH=8:
  - `a` = 0, `b` = 0xAB, `c` = 0x55 → `p_lo` = 0x55, `p_hi` = 0, `done` at 8 edges.
  - `a` = 14, `b` = 7, `c` = 2 → `p_lo` = 100.
- Abort, WIDTH=32:
  - Trigger `a` = 3, `b` = 4, `c` = 0; 10 cycles later trigger `a` = 5, `b` = 6, `c` = 1.
  - Required: exactly one `done`, 32 edges after the second trigger, with `p_lo` = 31.
  - Also trigger again on the completion edge and check that `done` and the result update are suppressed.
- Reset mid-operation: assert `rst` asynchronously between edges during step 5 → `busy`, `done`, `p_hi`, `p_lo` and `ovf` read 0 before the next edge; no `done` in the 64 cycles after release.
- Back-to-back: trigger `a` = 2, `b` = 3, `c` = 0, then trigger `a` = 4, `b` = 5, `c` = 6 in its `done` cycle → first `done` shows 6. `p_lo` stays 6 during the second computation; the second `done` follows 32 edges later with `p_lo` = 26.
